// File: rtl/uart_tx_buffered_if.sv
// Byte-store and status bundle between the MA-stage UART port and uart_tx_buffered.
// master = store-port side, slave = transmitter side.
interface uart_tx_buffered_if #(
  parameter int FIFO_AW = 4
);
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               ovf_clr;
  logic               tx;
  logic               full;
  logic               empty;
  logic [FIFO_AW:0]   level;
  logic               busy;
  logic               overflow;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  tx, full, empty, level, busy, overflow
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output tx, full, empty, level, busy, overflow
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: stored bytes are queued and sent as 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_tx_buffered_if.slave       bus
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BCW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCW-1:0]   BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0]   BAUD_ONE  = BCW'(1);
  localparam logic [FIFO_AW:0] PTR_ONE   = {{FIFO_AW{1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [BCW-1:0]   baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q;
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       head;
  logic [FIFO_AW:0] level;
  logic             full, empty, pop, push, drop, baud_done;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign head      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign push      = bus.wr_en && (!full || pop);
  assign drop      = bus.wr_en && full && !pop;
  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (drop)             ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_ONE;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (baud_done) state_d = DATA;
      DATA: begin
        if (baud_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_done) state_d = STOP;
`endif
      STOP: begin
        // Chain straight into the next start bit so queued frames are back to back.
        if (baud_done) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d  = head;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
    if (state_d != state_q) begin
      baud_d = '0;
      bit_d  = '0;
    end

    // tx is computed from the next state so the pin flop changes with the FSM.
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a frame-position model checks every cycle, directed vectors pin it.
module tb_uart_tx_buffered;
  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = (10 + PAR) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_tx_buffered_if #(.FIFO_AW(AW)) bus ();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: a byte queue plus the position inside the frame currently on the line.
  logic [7:0] m_q [$];
  logic [7:0] m_byte   = 8'h00;
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  bit         m_ovf    = 1'b0;
  bit         m_valid  = 1'b0;
  int         busy_cnt  = 0;
  int         max_level = 0;

  task automatic model_step();
    bit done, pop, push, drop;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      m_valid  = 1'b1;
      return;
    end
    done = m_active && (m_pos == FLEN - 1);
    pop  = (m_q.size() > 0) && (!m_active || done);
    push = bus.wr_en && ((m_q.size() < DEPTH) || pop);
    drop = bus.wr_en && !push;
    if (pop) begin
      m_byte   = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end else if (done) begin
      m_active = 1'b0;
      m_pos    = 0;
    end else if (m_active) begin
      m_pos++;
    end
    if (push) m_q.push_back(bus.wr_data);
    if (drop) m_ovf = 1'b1;
    else if (bus.ovf_clr) m_ovf = 1'b0;
  endtask

  function automatic logic model_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
    if (PAR == 1 && slot == 9) return ^m_byte;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare of {tx, busy, full, empty, overflow, level}.
  initial forever begin
    logic [7:0] act, exp;
    @(negedge clk);
    if (m_valid) begin
      act = {bus.tx, bus.busy, bus.full, bus.empty, bus.overflow, bus.level};
      exp = {model_tx(), m_active, (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf,
             3'(m_q.size())};
      check("cycle{tx,busy,full,empty,ovf,level}", int'(act), int'(exp));
      if (bus.busy) busy_cnt++;
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    $display("[TB] write 0x%02h at t=%0t", b, $time);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    int a5_seq [8];
    logic [7:0] burst [6];
    a5_seq      = '{1, 0, 1, 0, 0, 1, 0, 1};
    burst       = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    wait_edges(3);
    rst = 1'b0;

    // 1: idle after reset
    wait_edges(20);
    check("idle_tx", int'(bus.tx), 1);
    check("idle_empty", int'(bus.empty), 1);
    check("idle_full", int'(bus.full), 0);
    check("idle_level", int'(bus.level), 0);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_ovf", int'(bus.overflow), 0);

    // 2: single 0xA5 frame, write sampled at edge k
    write_byte(8'hA5);
    wait_edges(1);
    check("a5_start_tx", int'(bus.tx), 0);
    check("a5_start_busy", int'(bus.busy), 1);
    wait_edges(2);
    for (int i = 0; i < 8; i++) begin
      wait_edges(4);
      check($sformatf("a5_bit%0d", i), int'(bus.tx), a5_seq[i]);
    end
    wait_edges(4 + 4 * PAR);
    check("a5_stop_tx", int'(bus.tx), 1);
    wait_edges(1);
    check("a5_busy_last", int'(bus.busy), 1);
    wait_edges(1);
    check("a5_busy_drop", int'(bus.busy), 0);
    wait_edges(5);

    // 3: three consecutive writes, contiguous frames
    busy_cnt  = 0;
    max_level = 0;
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    wait_edges(3 * FLEN - 2);
    check("three_busy_end", int'(bus.busy), 1);
    wait_edges(1);
    check("three_busy_drop", int'(bus.busy), 0);
    check("three_max_level", max_level, 2);
    check("three_busy_cycles", busy_cnt, 3 * FLEN);
    wait_edges(5);

    // 4: overflow with 6 back-to-back writes
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) write_byte(burst[i]);
    check("ovf_level", int'(bus.level), 4);
    check("ovf_full", int'(bus.full), 1);
    check("ovf_flag", int'(bus.overflow), 1);
    wait_edges(5 * FLEN - 5);
    check("ovf_busy_end", int'(bus.busy), 1);
    wait_edges(1);
    check("ovf_busy_drop", int'(bus.busy), 0);
    check("ovf_busy_cycles", busy_cnt, 5 * FLEN);
    check("ovf_sticky", int'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    wait_edges(1);
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", int'(bus.overflow), 0);
    wait_edges(5);

    // 5: reset during data bit 3 of 0xFF with two bytes queued
    write_byte(8'hFF);
    write_byte(8'h11);
    write_byte(8'h22);
    check("rst_pre_level", int'(bus.level), 2);
    wait_edges(16);
    check("rst_bit3_tx", int'(bus.tx), 1);
    check("rst_bit3_busy", int'(bus.busy), 1);
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    check("rst_tx", int'(bus.tx), 1);
    check("rst_level", int'(bus.level), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_empty", int'(bus.empty), 1);
    busy_cnt = 0;
    wait_edges(60);
    check("rst_no_frames", busy_cnt, 0);

`ifdef UART_TX_PARITY_EN
    // 6: parity bit and 44-cycle frame
    write_byte(8'h07);
    wait_edges(39);
    check("par07_bit", int'(bus.tx), 1);
    wait_edges(5);
    check("par07_busy_end", int'(bus.busy), 1);
    wait_edges(1);
    check("par07_busy_drop", int'(bus.busy), 0);
    wait_edges(3);
    write_byte(8'h03);
    wait_edges(39);
    check("par03_bit", int'(bus.tx), 0);
    wait_edges(10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
